// File: rtl/lift_call_scheduler.sv
// Lift call scheduler for a 3-floor lift (g=0, f=1, s=2).
// Latches hall/car calls and picks the next target floor with a SCAN-style
// direction preference. It stops at an intermediate floor that has a call,
// and sequences each stop through door dwell, overload hold and call clear.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | parked at cur_flr, choosing the next stop from pending
//   MOVE    | travelling to tgt_flr, may retarget to a nearer stop
//   DWELL   | door dwell at cur_flr, down-counter runs to terminal 0
//   HOLD    | overload seen during dwell, waits for it to drop
module lift_call_scheduler #(
  parameter int NFLR  = 3,
  parameter int DWELL = 4,
  parameter int CW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NFLR-1:0] call_req,
  input  logic [1:0]      cur_flr,
  input  logic            door_open,
  input  logic            overload,
  output logic [1:0]      tgt_flr,
  output logic [NFLR-1:0] pending,
  output logic [1:0]      dir,
  output logic            busy,
  output logic            served
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  logic [1:0]      state_q, state_d;
  logic [1:0]      tgt_q, tgt_d;
  logic [1:0]      dir_q, dir_d;
  logic [NFLR-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            served_q, served_d;

  logic [NFLR-1:0] cur_oh, clr_mask;
  logic            flr_ok, cur_pend, call_cur;
  logic            up_ok, dn_ok, go_up, mid_stop;
  logic [1:0]      up_flr, dn_flr;

  // Floor decode and nearest pending floor above / below the current one.
  always_comb begin
    cur_oh   = NFLR'(1) << cur_flr;
    flr_ok   = (cur_flr != 2'b11);
    cur_pend = |(pend_q & cur_oh);
    call_cur = |(call_req & cur_oh);

    up_ok  = 1'b0;
    up_flr = cur_flr;
    dn_ok  = 1'b0;
    dn_flr = cur_flr;
    case (cur_flr)
      2'd0: begin
        if (pend_q[1]) begin
          up_ok  = 1'b1;
          up_flr = 2'd1;
        end else if (pend_q[2]) begin
          up_ok  = 1'b1;
          up_flr = 2'd2;
        end
      end
      2'd1: begin
        if (pend_q[2]) begin
          up_ok  = 1'b1;
          up_flr = 2'd2;
        end
        if (pend_q[0]) begin
          dn_ok  = 1'b1;
          dn_flr = 2'd0;
        end
      end
      2'd2: begin
        if (pend_q[1]) begin
          dn_ok  = 1'b1;
          dn_flr = 2'd1;
        end else if (pend_q[0]) begin
          dn_ok  = 1'b1;
          dn_flr = 2'd0;
        end
      end
      default: ;
    endcase

    // Keep the last travel direction while calls remain that way; only a
    // downward history prefers going down first.
    go_up = (dir_q == DIR_DN) ? !dn_ok : up_ok;

    // With three floors the only possible intermediate stop is floor 1,
    // reachable when travelling end to end.
    mid_stop = pend_q[1] &&
               (((cur_flr == 2'd0) && (tgt_q == 2'd2)) ||
                ((cur_flr == 2'd2) && (tgt_q == 2'd0)));
  end

  // Service sequencing: target selection, travel, dwell timer and clear.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    served_d = 1'b0;
    clr_mask = '0;

    // An invalid floor code freezes the sequencer; calls still latch below.
    if (flr_ok) begin
      case (state_q)
        S_IDLE: begin
          tgt_d = cur_flr;
          if (cur_pend) begin
            state_d = S_DWELL;
            cnt_d   = RELOAD;
          end else if (|pend_q) begin
            state_d = S_MOVE;
            tgt_d   = go_up ? up_flr : dn_flr;
            dir_d   = go_up ? DIR_UP : DIR_DN;
          end else begin
            dir_d = DIR_IDLE;
          end
        end
        S_MOVE: begin
          if (!overload) begin
            if ((cur_flr == tgt_q) && door_open) begin
              state_d = S_DWELL;
              cnt_d   = RELOAD;
            end else if (mid_stop) begin
              tgt_d = 2'd1;
            end
          end
        end
        S_DWELL: begin
          if (overload) begin
            state_d = S_HOLD;
          end else if ((cnt_q == '0) && door_open) begin
            // A fresh call for this floor in the clear cycle re-sets the
            // bit through pend_d, so the floor is served again at once.
            clr_mask = cur_oh;
            served_d = 1'b1;
            state_d  = S_IDLE;
          end else if (call_cur) begin
            cnt_d = RELOAD;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          tgt_d = cur_flr;
          if (!overload) begin
            state_d = S_DWELL;
            cnt_d   = RELOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    pend_d = (pend_q & ~clr_mask) | call_req;
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tgt_q    <= 2'd0;
      dir_q    <= DIR_IDLE;
      pend_q   <= '0;
      cnt_q    <= '0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
    end
  end

  assign tgt_flr = tgt_q;
  assign pending = pend_q;
  assign dir     = dir_q;
  assign busy    = (state_q != S_IDLE);
  assign served  = served_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed self-checking bench for lift_call_scheduler.
// One task per scenario; a second instance with DWELL=1 covers the
// shortest dwell.
module tb_lift_call_scheduler;

  logic       clk = 1'b0;
  logic       rst, rst1;
  logic [2:0] call_req;
  logic [1:0] cur_flr;
  logic       door_open, overload;
  logic [1:0] tgt_flr, dir, tgt1, dir1;
  logic [2:0] pending, pending1;
  logic       busy, served, busy1, served1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] srv_flr[4];
  logic [1:0] nxt_tgt[4];
  logic [1:0] nxt_dir[4];
  int         n_srv;

  lift_call_scheduler #(.NFLR(3), .DWELL(4), .CW(4)) u_dut (
    .clk(clk), .rst(rst), .call_req(call_req), .cur_flr(cur_flr),
    .door_open(door_open), .overload(overload), .tgt_flr(tgt_flr),
    .pending(pending), .dir(dir), .busy(busy), .served(served));

  lift_call_scheduler #(.NFLR(3), .DWELL(1), .CW(4)) u_one (
    .clk(clk), .rst(rst1), .call_req(call_req), .cur_flr(cur_flr),
    .door_open(door_open), .overload(overload), .tgt_flr(tgt1),
    .pending(pending1), .dir(dir1), .busy(busy1), .served(served1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lift model: one floor per cycle toward tgt_flr, door open on arrival.
  task automatic lift_model();
    if (cur_flr != 2'b11 && cur_flr != tgt_flr) begin
      if (cur_flr < tgt_flr) cur_flr = cur_flr + 2'd1;
      else                   cur_flr = cur_flr - 2'd1;
    end
    door_open = (cur_flr == tgt_flr);
  endtask

  // Runs the lift model, recording each served floor and the target/dir
  // chosen on the cycle after each service.
  task automatic run_auto(input int budget, input int nexp);
    bit cap;
    cap   = 1'b0;
    n_srv = 0;
    lift_model();
    for (int c = 0; c < budget; c++) begin
      tick();
      if (cap) begin
        nxt_tgt[n_srv-1] = tgt_flr;
        nxt_dir[n_srv-1] = dir;
        cap = 1'b0;
        if (n_srv == nexp) break;
      end
      if (served === 1'b1 && n_srv < 4) begin
        srv_flr[n_srv] = cur_flr;
        n_srv++;
        cap = 1'b1;
      end
      lift_model();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1; call_req = 3'b000; cur_flr = 2'd0;
    door_open = 1'b0; overload = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (pending !== 3'b000) begin n_fail++; $display("FAIL reset_pending got %b exp 000", pending); end
    n_checks++; if (tgt_flr !== 2'd0) begin n_fail++; $display("FAIL reset_tgt got %0d exp 0", tgt_flr); end
    n_checks++; if (dir !== 2'b00) begin n_fail++; $display("FAIL reset_dir got %b exp 00", dir); end
    n_checks++; if (busy !== 1'b0 || served !== 1'b0) begin n_fail++; $display("FAIL reset_busy_served got %b%b exp 00", busy, served); end
  endtask

  task automatic test_single_call();
    call_req = 3'b100;
    tick();
    call_req = 3'b000;
    n_checks++; if (pending !== 3'b100) begin n_fail++; $display("FAIL single_pending got %b exp 100", pending); end
    n_checks++; if (tgt_flr !== 2'd0) begin n_fail++; $display("FAIL single_tgt_early got %0d exp 0", tgt_flr); end
    tick();
    n_checks++; if (tgt_flr !== 2'd2 || dir !== 2'b01) begin n_fail++; $display("FAIL single_tgt_dir got %0d/%b exp 2/01", tgt_flr, dir); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
    cur_flr = 2'd1; door_open = 1'b0;
    tick();
    cur_flr = 2'd2; door_open = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (served !== 1'b0) begin n_fail++; $display("FAIL single_early_served cycle %0d got %b exp 0", i, served); end
    end
    tick();
    n_checks++; if (served !== 1'b1) begin n_fail++; $display("FAIL single_served got %b exp 1", served); end
    n_checks++; if (pending !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after got pend %b busy %b exp 000 0", pending, busy); end
    tick();
    n_checks++; if (served !== 1'b0 || dir !== 2'b00) begin n_fail++; $display("FAIL single_idle got served %b dir %b exp 0 00", served, dir); end
  endtask

  task automatic test_scan_down();
    call_req = 3'b010;
    tick();
    call_req = 3'b101;
    tick();
    call_req = 3'b000;
    n_checks++; if (tgt_flr !== 2'd1 || dir !== 2'b10) begin n_fail++; $display("FAIL scan_first got %0d/%b exp 1/10", tgt_flr, dir); end
    run_auto(80, 3);
    n_checks++; if (n_srv !== 3) begin n_fail++; $display("FAIL scan_count got %0d exp 3", n_srv); end
    n_checks++; if (srv_flr[0] !== 2'd1 || srv_flr[1] !== 2'd0 || srv_flr[2] !== 2'd2) begin n_fail++; $display("FAIL scan_order got %0d,%0d,%0d exp 1,0,2", srv_flr[0], srv_flr[1], srv_flr[2]); end
    n_checks++; if (nxt_tgt[0] !== 2'd0 || nxt_dir[0] !== 2'b10) begin n_fail++; $display("FAIL scan_down_pick got %0d/%b exp 0/10", nxt_tgt[0], nxt_dir[0]); end
    n_checks++; if (nxt_tgt[1] !== 2'd2 || nxt_dir[1] !== 2'b01) begin n_fail++; $display("FAIL scan_up_pick got %0d/%b exp 2/01", nxt_tgt[1], nxt_dir[1]); end
  endtask

  task automatic test_overload();
    cur_flr = 2'd2; door_open = 1'b1;
    call_req = 3'b100;
    tick();
    call_req = 3'b000;
    tick();
    tick();
    overload = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (served !== 1'b0 || tgt_flr !== 2'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL hold cycle %0d got srv %b tgt %0d busy %b exp 0 2 1", i, served, tgt_flr, busy); end
    end
    overload = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (served !== 1'b0) begin n_fail++; $display("FAIL hold_redwell cycle %0d got %b exp 0", i, served); end
    end
    tick();
    n_checks++; if (served !== 1'b1 || pending !== 3'b000) begin n_fail++; $display("FAIL hold_served got srv %b pend %b exp 1 000", served, pending); end
  endtask

  task automatic test_clear_recall();
    call_req = 3'b100;
    tick();
    call_req = 3'b000;
    tick();
    tick();
    call_req = 3'b100;
    tick();
    call_req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (served !== 1'b0) begin n_fail++; $display("FAIL reload_early cycle %0d got %b exp 0", i, served); end
    end
    call_req = 3'b100;
    tick();
    call_req = 3'b000;
    n_checks++; if (served !== 1'b1 || pending !== 3'b100) begin n_fail++; $display("FAIL setwins got srv %b pend %b exp 1 100", served, pending); end
    tick();
    n_checks++; if (served !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL reserve_start got srv %b busy %b exp 0 1", served, busy); end
    for (int i = 0; i < 3; i++) tick();
    tick();
    n_checks++; if (served !== 1'b1 || pending !== 3'b000) begin n_fail++; $display("FAIL reserve_done got srv %b pend %b exp 1 000", served, pending); end
  endtask

  task automatic test_rst_mid_move();
    call_req = 3'b011;
    tick();
    call_req = 3'b000;
    tick();
    tick();
    n_checks++; if (busy !== 1'b1 || pending !== 3'b011 || tgt_flr !== 2'd1) begin n_fail++; $display("FAIL premove got busy %b pend %b tgt %0d exp 1 011 1", busy, pending, tgt_flr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (pending !== 3'b000 || tgt_flr !== 2'd0 || dir !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_abort got pend %b tgt %0d dir %b busy %b exp 000 0 00 0", pending, tgt_flr, dir, busy); end
  endtask

  task automatic test_retarget();
    cur_flr = 2'd0; door_open = 1'b0;
    tick();
    call_req = 3'b100;
    tick();
    call_req = 3'b010;
    tick();
    call_req = 3'b000;
    n_checks++; if (tgt_flr !== 2'd2 || dir !== 2'b01) begin n_fail++; $display("FAIL retgt_first got %0d/%b exp 2/01", tgt_flr, dir); end
    tick();
    n_checks++; if (tgt_flr !== 2'd1) begin n_fail++; $display("FAIL retgt_mid got %0d exp 1", tgt_flr); end
    run_auto(60, 2);
    n_checks++; if (n_srv !== 2) begin n_fail++; $display("FAIL retgt_count got %0d exp 2", n_srv); end
    n_checks++; if (srv_flr[0] !== 2'd1 || srv_flr[1] !== 2'd2) begin n_fail++; $display("FAIL retgt_order got %0d,%0d exp 1,2", srv_flr[0], srv_flr[1]); end
    n_checks++; if (nxt_tgt[0] !== 2'd2 || nxt_dir[0] !== 2'b01) begin n_fail++; $display("FAIL retgt_next got %0d/%b exp 2/01", nxt_tgt[0], nxt_dir[0]); end
    n_checks++; if (pending !== 3'b000 || dir !== 2'b00) begin n_fail++; $display("FAIL retgt_end got pend %b dir %b exp 000 00", pending, dir); end
  endtask

  task automatic test_invalid_floor();
    rst = 1'b1; cur_flr = 2'd0; door_open = 1'b0;
    tick();
    rst = 1'b0;
    call_req = 3'b100;
    tick();
    call_req = 3'b000;
    tick();
    cur_flr = 2'b11; call_req = 3'b010;
    tick();
    call_req = 3'b000;
    n_checks++; if (tgt_flr !== 2'd2 || pending !== 3'b110 || busy !== 1'b1) begin n_fail++; $display("FAIL invalid_freeze got tgt %0d pend %b busy %b exp 2 110 1", tgt_flr, pending, busy); end
    tick();
    n_checks++; if (tgt_flr !== 2'd2) begin n_fail++; $display("FAIL invalid_hold got %0d exp 2", tgt_flr); end
    cur_flr = 2'd0;
    tick();
    n_checks++; if (tgt_flr !== 2'd1) begin n_fail++; $display("FAIL invalid_resume got %0d exp 1", tgt_flr); end
  endtask

  task automatic test_dwell_one();
    rst1 = 1'b0; cur_flr = 2'd0; door_open = 1'b1; overload = 1'b0;
    call_req = 3'b001;
    tick();
    call_req = 3'b000;
    n_checks++; if (pending1 !== 3'b001) begin n_fail++; $display("FAIL d1_pending got %b exp 001", pending1); end
    tick();
    n_checks++; if (served1 !== 1'b0 || busy1 !== 1'b1) begin n_fail++; $display("FAIL d1_enter got srv %b busy %b exp 0 1", served1, busy1); end
    tick();
    n_checks++; if (served1 !== 1'b1 || pending1 !== 3'b000) begin n_fail++; $display("FAIL d1_served got srv %b pend %b exp 1 000", served1, pending1); end
    tick();
    n_checks++; if (served1 !== 1'b0) begin n_fail++; $display("FAIL d1_pulse got %b exp 0", served1); end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan_down();
    test_overload();
    test_clear_recall();
    test_rst_mid_move();
    test_retarget();
    test_invalid_floor();
    test_dwell_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
